// File: rtl/booth_r8_pkg.sv
// Shared types and helpers for the radix-8 Booth row feeder.
// Holds the group-count derivation, the per-group flag struct and the digit encoder.
package booth_r8_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef struct packed {
        logic s;
        logic d;
        logic t;
        logic q;
        logic n;
    } grp_flags_t;

    function automatic int unsigned gc_of(input int unsigned width);
        return (width >> 2) + 1;
    endfunction

    // Digit is two's complement in -4..4; magnitude selects exactly one of S/D/T/Q.
    function automatic grp_flags_t encode_digit(input logic [DIGIT_W-1:0] digit);
        grp_flags_t         f;
        logic [DIGIT_W-1:0] mag;
        mag = digit[DIGIT_W-1] ? (~digit + DIGIT_W'(1)) : digit;
        f.s = (mag == DIGIT_W'(1));
        f.d = (mag == DIGIT_W'(2));
        f.t = (mag == DIGIT_W'(3));
        f.q = (mag == DIGIT_W'(4));
        f.n = digit[DIGIT_W-1];
        return f;
    endfunction

endpackage

// File: rtl/booth_r8_enc.sv
// Combinational radix-8 Booth encoder for one 4-bit window (b3,b2,b1,b0).
module booth_r8_enc
    import booth_r8_pkg::*;
(
    input  logic [3:0] i_win,
    output grp_flags_t o_flags
);

    logic [DIGIT_W-1:0] w_pos;
    logic [DIGIT_W-1:0] w_digit;

    always_comb begin
        w_pos   = {2'b00, i_win[2], 1'b0} + {3'b000, i_win[1]} + {3'b000, i_win[0]};
        w_digit = w_pos - (i_win[3] ? DIGIT_W'(4) : DIGIT_W'(0));
        o_flags = encode_digit(w_digit);
    end

endmodule

// File: rtl/booth_r8_row_feeder.sv
// Buffers X/Y operand beats, Booth-encodes X per group and feeds one row per RUN cycle,
// emitting bubbles on underrun and tracking tile boundaries against IN_LAST.
module booth_r8_row_feeder
    import booth_r8_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GC    = gc_of(WIDTH),
    parameter int unsigned DEPTH = 4,
    parameter int unsigned K_LEN = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] X_IN,
    input  logic [WIDTH-1:0] Y_IN,
    input  logic             IN_LAST,
    input  logic             RUN,
    output logic [GC-1:0]    S_OUT,
    output logic [GC-1:0]    D_OUT,
    output logic [GC-1:0]    T_OUT,
    output logic [GC-1:0]    Q_OUT,
    output logic [GC-1:0]    N_OUT,
    output logic [WIDTH-1:0] Y_OUT,
    output logic [WIDTH+1:0] TMY_OUT,
    output logic             TILE_DONE,
    output logic             UNDERRUN,
    output logic             LAST_ERR
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned BEAT_W = (K_LEN > 1) ? $clog2(K_LEN) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(K_LEN - 1);

    if (WIDTH != 8) begin : g_bad_width
        $error("booth_r8_row_feeder: only WIDTH=8 is supported");
    end
    if (GC != gc_of(WIDTH)) begin : g_bad_gc
        $error("booth_r8_row_feeder: GC must equal (WIDTH>>2)+1");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("booth_r8_row_feeder: DEPTH must be a power of two and at least 2");
    end
    if (K_LEN < 2) begin : g_bad_klen
        $error("booth_r8_row_feeder: K_LEN must be at least 2");
    end

    // Inline FIFO storage; contents need no reset since count gates every read.
    logic [WIDTH-1:0] r_x_mem [DEPTH];
    logic [WIDTH-1:0] r_y_mem [DEPTH];
    logic [DEPTH-1:0] r_last_mem;

    logic [PTR_W-1:0]  r_wptr, r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ready;
    logic [BEAT_W-1:0] r_beat;
    logic [GC-1:0]     r_s, r_d, r_t, r_q, r_n;
    logic [WIDTH-1:0]  r_y;
    logic [WIDTH+1:0]  r_tmy;
    logic              r_done, r_under, r_last_err;

    logic [PTR_W-1:0]  w_wptr_nxt, w_rptr_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_ready_nxt;
    logic [BEAT_W-1:0] w_beat_nxt;
    logic [GC-1:0]     w_s_nxt, w_d_nxt, w_t_nxt, w_q_nxt, w_n_nxt;
    logic [WIDTH-1:0]  w_y_nxt;
    logic [WIDTH+1:0]  w_tmy_nxt;
    logic              w_done_nxt, w_under_nxt, w_last_err_nxt;

    logic              w_push, w_pop, w_beat_last;
    logic [WIDTH-1:0]  w_head_x, w_head_y;
    logic              w_head_last;
    logic [WIDTH+1:0]  w_xe;
    logic [WIDTH+1:0]  w_tmy;
    logic [GC-1:0]     w_enc_s, w_enc_d, w_enc_t, w_enc_q, w_enc_n;

    assign w_push      = IN_VALID && r_ready && !RST;
    assign w_pop       = RUN && (r_count != '0);
    assign w_beat_last = (r_beat == BEAT_LAST);

    assign w_head_x    = r_x_mem[r_rptr];
    assign w_head_y    = r_y_mem[r_rptr];
    assign w_head_last = r_last_mem[r_rptr];

    // x[8]=x[7] on top, x[-1]=0 at bit 0: group i reads w_xe[3i+3:3i].
    assign w_xe  = {w_head_x[WIDTH-1], w_head_x, 1'b0};
    assign w_tmy = {{2{w_head_y[WIDTH-1]}}, w_head_y} + {w_head_y[WIDTH-1], w_head_y, 1'b0};

    for (genvar gi = 0; gi < GC; gi++) begin : g_enc
        grp_flags_t w_flags;

        booth_r8_enc u_enc (
            .i_win  (w_xe[3*gi+3 -: 4]),
            .o_flags(w_flags)
        );

        assign w_enc_s[gi] = w_flags.s;
        assign w_enc_d[gi] = w_flags.d;
        assign w_enc_t[gi] = w_flags.t;
        assign w_enc_q[gi] = w_flags.q;
        assign w_enc_n[gi] = w_flags.n;
    end

    always_comb begin
        w_wptr_nxt     = r_wptr;
        w_rptr_nxt     = r_rptr;
        w_count_nxt    = r_count;
        w_beat_nxt     = r_beat;
        w_s_nxt        = r_s;
        w_d_nxt        = r_d;
        w_t_nxt        = r_t;
        w_q_nxt        = r_q;
        w_n_nxt        = r_n;
        w_y_nxt        = r_y;
        w_tmy_nxt      = r_tmy;
        w_done_nxt     = 1'b0;
        w_under_nxt    = 1'b0;
        w_last_err_nxt = r_last_err;

        if (w_push) begin
            w_wptr_nxt = r_wptr + PTR_W'(1);
        end

        if (w_pop) begin
            w_rptr_nxt = r_rptr + PTR_W'(1);
            w_s_nxt    = w_enc_s;
            w_d_nxt    = w_enc_d;
            w_t_nxt    = w_enc_t;
            w_q_nxt    = w_enc_q;
            w_n_nxt    = w_enc_n;
            w_y_nxt    = w_head_y;
            w_tmy_nxt  = w_tmy;
            if (w_beat_last) begin
                w_beat_nxt = '0;
                w_done_nxt = 1'b1;
            end else begin
                w_beat_nxt = r_beat + BEAT_W'(1);
            end
            if (w_head_last != w_beat_last) begin
                w_last_err_nxt = 1'b1;
            end
        end else if (RUN) begin
            w_s_nxt     = '0;
            w_d_nxt     = '0;
            w_t_nxt     = '0;
            w_q_nxt     = '0;
            w_n_nxt     = '0;
            w_y_nxt     = '0;
            w_tmy_nxt   = '0;
            w_under_nxt = 1'b1;
        end

        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase

        // Registered ready: no bypass of a same-cycle pop when full.
        w_ready_nxt = (w_count_nxt < DEPTH_C);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ready    <= 1'b0;
            r_beat     <= '0;
            r_s        <= '0;
            r_d        <= '0;
            r_t        <= '0;
            r_q        <= '0;
            r_n        <= '0;
            r_y        <= '0;
            r_tmy      <= '0;
            r_done     <= 1'b0;
            r_under    <= 1'b0;
            r_last_err <= 1'b0;
        end else begin
            r_wptr     <= w_wptr_nxt;
            r_rptr     <= w_rptr_nxt;
            r_count    <= w_count_nxt;
            r_ready    <= w_ready_nxt;
            r_beat     <= w_beat_nxt;
            r_s        <= w_s_nxt;
            r_d        <= w_d_nxt;
            r_t        <= w_t_nxt;
            r_q        <= w_q_nxt;
            r_n        <= w_n_nxt;
            r_y        <= w_y_nxt;
            r_tmy      <= w_tmy_nxt;
            r_done     <= w_done_nxt;
            r_under    <= w_under_nxt;
            r_last_err <= w_last_err_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_x_mem[r_wptr]    <= X_IN;
            r_y_mem[r_wptr]    <= Y_IN;
            r_last_mem[r_wptr] <= IN_LAST;
        end
    end

    assign IN_READY  = r_ready;
    assign S_OUT     = r_s;
    assign D_OUT     = r_d;
    assign T_OUT     = r_t;
    assign Q_OUT     = r_q;
    assign N_OUT     = r_n;
    assign Y_OUT     = r_y;
    assign TMY_OUT   = r_tmy;
    assign TILE_DONE = r_done;
    assign UNDERRUN  = r_under;
    assign LAST_ERR  = r_last_err;

endmodule

// File: tb/tb_booth_r8_row_feeder.sv
// Scoreboard bench for booth_r8_row_feeder: stimulus queues expected rows, a monitor
// pops and compares one row for every clock edge that saw RUN=1 outside reset.
module tb_booth_r8_row_feeder;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [7:0] X_IN = '0;
    logic [7:0] Y_IN = '0;
    logic       IN_LAST = 1'b0;
    logic       RUN = 1'b0;
    logic [2:0] S_OUT, D_OUT, T_OUT, Q_OUT, N_OUT;
    logic [7:0] Y_OUT;
    logic [9:0] TMY_OUT;
    logic       TILE_DONE, UNDERRUN, LAST_ERR;

    always #5 CLK = ~CLK;

    booth_r8_row_feeder #(
        .WIDTH(8),
        .DEPTH(4),
        .K_LEN(16)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .X_IN     (X_IN),
        .Y_IN     (Y_IN),
        .IN_LAST  (IN_LAST),
        .RUN      (RUN),
        .S_OUT    (S_OUT),
        .D_OUT    (D_OUT),
        .T_OUT    (T_OUT),
        .Q_OUT    (Q_OUT),
        .N_OUT    (N_OUT),
        .Y_OUT    (Y_OUT),
        .TMY_OUT  (TMY_OUT),
        .TILE_DONE(TILE_DONE),
        .UNDERRUN (UNDERRUN),
        .LAST_ERR (LAST_ERR)
    );

    typedef struct packed {
        logic       chk_flags;
        logic [2:0] s, d, t, q, n;
        logic [7:0] x;
        logic [7:0] y;
        logic [9:0] tmy;
        logic       td, ur, le;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [9:0] tmy3(input logic [7:0] y);
        int v;
        v = 3 * int'($signed(y));
        return v[9:0];
    endfunction

    function automatic int digit_sum(input logic [2:0] s, d, t, q, n);
        int sum;
        sum = 0;
        for (int i = 0; i < 3; i++) begin
            int mag;
            if (int'(s[i]) + int'(d[i]) + int'(t[i]) + int'(q[i]) > 1) return 9999;
            mag = s[i] ? 1 : d[i] ? 2 : t[i] ? 3 : q[i] ? 4 : 0;
            if (n[i] && mag == 0) return 9999;
            sum += (n[i] ? -mag : mag) * (1 << (3 * i));
        end
        return sum;
    endfunction

    function automatic exp_t e_dir(input logic [2:0] s, d, t, q, n, input logic [7:0] y,
                                   input logic [9:0] tmy);
        exp_t e;
        e = '0;
        e.chk_flags = 1'b1;
        e.s = s; e.d = d; e.t = t; e.q = q; e.n = n;
        e.y = y;
        e.tmy = tmy;
        return e;
    endfunction

    function automatic exp_t e_sum(input logic [7:0] x, y, input logic td, le);
        exp_t e;
        e = '0;
        e.x = x;
        e.y = y;
        e.tmy = tmy3(y);
        e.td = td;
        e.le = le;
        return e;
    endfunction

    function automatic exp_t e_bub(input logic le);
        exp_t e;
        e = '0;
        e.chk_flags = 1'b1;
        e.ur = 1'b1;
        e.le = le;
        return e;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [7:0] x, y, input logic last, exp_ready, track,
                        input exp_t e);
        IN_VALID = 1'b1;
        X_IN = x;
        Y_IN = y;
        IN_LAST = last;
        check("in_ready", IN_READY, exp_ready);
        if (exp_ready && track) exp_q.push_back(e);
        step();
        IN_VALID = 1'b0;
        IN_LAST = 1'b0;
    endtask

    task automatic stream(input logic [7:0] x, y, input exp_t e);
        IN_VALID = 1'b1;
        RUN = 1'b1;
        X_IN = x;
        Y_IN = y;
        check("stream_ready", IN_READY, 1'b1);
        exp_q.push_back(e);
        step();
        IN_VALID = 1'b0;
        RUN = 1'b0;
    endtask

    task automatic run(input int n);
        RUN = 1'b1;
        repeat (n) step();
        RUN = 1'b0;
    endtask

    // Drives RUN and IN_VALID during reset: reset must win over both.
    task automatic do_reset();
        RST = 1'b1;
        IN_VALID = 1'b1;
        RUN = 1'b1;
        X_IN = 8'h11;
        Y_IN = 8'h22;
        step();
        step();
        check("rst_outputs", {S_OUT, D_OUT, T_OUT, Q_OUT, N_OUT, Y_OUT, TMY_OUT,
                              TILE_DONE, UNDERRUN, LAST_ERR}, '0);
        RST = 1'b0;
        IN_VALID = 1'b0;
        RUN = 1'b0;
        step();
        check("rst_ready", IN_READY, 1'b1);
    endtask

    // 16 beats in bursts of 4; expected LAST_ERR from index le_from onward.
    task automatic tile(input int last_at, input int le_from);
        logic [7:0] x, y;
        for (int k = 0; k < 16; k++) begin
            x = 8'(k * 17 + 3);
            y = 8'(k * 5 + 1);
            push(x, y, k == last_at, 1'b1, 1'b1,
                 e_sum(x, y, k == 15, (le_from >= 0) && (k >= le_from)));
            if (k % 4 == 3) run(4);
        end
    endtask

    task automatic monitor();
        logic ran;
        exp_t e;
        int   idx;
        idx = 0;
        forever begin
            @(posedge CLK);
            ran = RUN && !RST;
            @(negedge CLK);
            if (ran) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_row: got a row with no expectation queued");
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk_flags) begin
                        check($sformatf("row%0d", idx),
                              {S_OUT, D_OUT, T_OUT, Q_OUT, N_OUT, Y_OUT, TMY_OUT,
                               TILE_DONE, UNDERRUN, LAST_ERR},
                              {e.s, e.d, e.t, e.q, e.n, e.y, e.tmy, e.td, e.ur, e.le});
                    end else begin
                        check($sformatf("row%0d_digit_sum", idx),
                              digit_sum(S_OUT, D_OUT, T_OUT, Q_OUT, N_OUT),
                              int'($signed(e.x)));
                        check($sformatf("row%0d_data", idx),
                              {Y_OUT, TMY_OUT, TILE_DONE, UNDERRUN, LAST_ERR},
                              {e.y, e.tmy, e.td, e.ur, e.le});
                    end
                end
                idx++;
            end
        end
    endtask

    task automatic stimulus();
        logic [7:0] x, y;
        do_reset();

        // Directed encodings; the fifth push finds the FIFO full and is dropped.
        push(8'h07, 8'h05, 1'b0, 1'b1, 1'b1,
             e_dir(3'b011, 3'b000, 3'b000, 3'b000, 3'b001, 8'h05, 10'h00F));
        push(8'h80, 8'h80, 1'b0, 1'b1, 1'b1,
             e_dir(3'b000, 3'b100, 3'b000, 3'b000, 3'b100, 8'h80, 10'h280));
        push(8'h7F, 8'h01, 1'b0, 1'b1, 1'b1,
             e_dir(3'b001, 3'b100, 3'b000, 3'b000, 3'b001, 8'h01, 10'h003));
        push(8'h24, 8'hC0, 1'b0, 1'b1, 1'b1,
             e_dir(3'b100, 3'b000, 3'b010, 3'b001, 3'b011, 8'hC0, 10'h340));
        push(8'hAA, 8'hAA, 1'b0, 1'b0, 1'b0, e_bub(1'b0));
        run(3);
        repeat (3) step();
        check("hold_y", Y_OUT, 8'h01);
        check("hold_flags", {S_OUT, D_OUT, N_OUT}, {3'b001, 3'b100, 3'b001});
        check("hold_pulses", {TILE_DONE, UNDERRUN}, 2'b00);
        exp_q.push_back(e_bub(1'b0));
        run(2);
        push(8'hFF, 8'h7F, 1'b0, 1'b1, 1'b1,
             e_dir(3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 8'h7F, 10'h17D));
        run(1);

        // Simultaneous push and pop keep the FIFO at two entries while pointers wrap.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            x = 8'(8'h31 + i * 8'h13);
            y = 8'(8'h90 + i);
            push(x, y, 1'b0, 1'b1, 1'b1, e_sum(x, y, 1'b0, 1'b0));
        end
        for (int i = 0; i < 6; i++) begin
            x = 8'(8'hC5 + i * 8'h27);
            y = 8'(8'h7A - i * 8'h11);
            stream(x, y, e_sum(x, y, 1'b0, 1'b0));
        end
        run(2);

        // Tile boundaries: correct IN_LAST, then IN_LAST one beat early.
        do_reset();
        tile(15, -1);
        tile(14, 14);
        repeat (2) step();
        check("last_err_sticky", LAST_ERR, 1'b1);

        // Reset after beat 7 drops queued beats and the partial tile count.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            x = 8'(k * 29 + 7);
            y = 8'(k * 3);
            push(x, y, 1'b0, 1'b1, 1'b1, e_sum(x, y, 1'b0, 1'b0));
            if (k == 3) run(4);
        end
        run(3);
        push(8'h5C, 8'h12, 1'b0, 1'b1, 1'b0, e_bub(1'b0));
        push(8'h6D, 8'h34, 1'b0, 1'b1, 1'b0, e_bub(1'b0));
        do_reset();
        exp_q.push_back(e_bub(1'b0));
        run(1);
        tile(15, -1);

        // All 256 X values: digit sum must reproduce X.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            x = 8'(i);
            y = x ^ 8'h5A;
            push(x, y, (i % 16) == 15, 1'b1, 1'b1, e_sum(x, y, (i % 16) == 15, 1'b0));
            if (i % 4 == 3) run(4);
        end

        repeat (3) step();
        check("sb_drain", exp_q.size(), 0);
    endtask

    initial begin
        fork
            monitor();
            stimulus();
            begin
                #200000;
                n_checks++;
                n_errors++;
                $display("FAIL timeout: stimulus did not complete within 200000 time units");
            end
        join_any
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/booth_r8_row_feeder.md
BOOTH_R8_ROW_FEEDER -- requirements
Module: booth_r8_row_feeder

Interface
REQ-001 Parameter WIDTH, default 8, operand width; only 8 is supported, and any other value SHALL fail elaboration.
REQ-002 Parameter GC, default (WIDTH>>2)+1 = 3, number of radix-8 Booth groups per operand.
REQ-003 Parameter DEPTH, default 4, input FIFO entries, a power of two and at least 2.
REQ-004 Parameter K_LEN, default 16, number of operand beats per output tile.
REQ-005 The block SHALL use one clock and a synchronous active-high reset:
- CLK  in  1  clock; all state on the rising edge.
- RST  in  1  synchronous reset, active-high.
REQ-006 The block SHALL have these ports:
- IN_VALID  in  1  operand beat offered.
- IN_READY  out  1  FIFO can accept a beat.
- X_IN  in  WIDTH  signed multiplier operand, to be Booth-encoded.
- Y_IN  in  WIDTH  signed multiplicand operand.
- IN_LAST  in  1  marks the last beat of a tile.
- RUN  in  1  array controller advance enable.
- S_OUT, D_OUT, T_OUT, Q_OUT, N_OUT  out  GC each  per-group one-hot magnitude (1/2/3/4) and negate flags.
- Y_OUT  out  WIDTH  registered Y.
- TMY_OUT  out  WIDTH+2  registered 3*Y, signed.
- TILE_DONE  out  1  one-cycle pulse at tile end.
- UNDERRUN  out  1  one-cycle pulse when a bubble is emitted.
- LAST_ERR  out  1  sticky IN_LAST/count mismatch.

Function
REQ-007 FIFO push SHALL occur when IN_VALID and IN_READY are both high; IN_READY SHALL be (count < DEPTH), with no same-cycle pop bypass when full.
REQ-008 A pushed beat SHALL NOT pop in its push cycle; the earliest pop is the next cycle.
REQ-009 When RUN=1 and the FIFO is not empty, the block SHALL pop one beat, and the outputs SHALL show the encoded beat in the next cycle (latency 1).
REQ-010 When RUN=1 and the FIFO is empty, the block SHALL emit a bubble next cycle: all S/D/T/Q/N=0, Y_OUT=0, TMY_OUT=0, UNDERRUN=1.
REQ-011 When RUN=0, the block SHALL NOT pop and SHALL hold all data outputs; UNDERRUN and TILE_DONE SHALL be 0.
REQ-012 Encoding SHALL treat X as 9 bits with x[8]=x[7] and x[-1]=0.
REQ-013 Group i SHALL take bits (x[3i+2],x[3i+1],x[3i],x[3i-1]) and form digit = -4*b3 + 2*b2 + b1 + b0, range -4..4.
REQ-014 Per group, exactly one of S/D/T/Q SHALL be set for |digit| 1/2/3/4, none for digit 0; N SHALL equal (digit<0); sum of digit_i*8^i SHALL equal X.
REQ-015 TMY_OUT SHALL be 3*Y sign-extended to WIDTH+2 bits, never overflowing.
REQ-016 A beat counter SHALL increment per popped beat; on reaching K_LEN-1 it SHALL wrap to 0 and TILE_DONE SHALL pulse in the same cycle that beat appears on the outputs.
REQ-017 Bubbles SHALL NOT advance the beat counter.
REQ-018 If a popped beat has IN_LAST != (counter==K_LEN-1), LAST_ERR SHALL set and stay set until RST; the counter SHALL still follow REQ-016.
REQ-019 A simultaneous push and pop SHALL keep the count unchanged, with pointers wrapping modulo DEPTH.

Reset
REQ-020 While RST=1, the FIFO count, pointers and beat counter SHALL clear to 0.
REQ-021 While RST=1, all outputs SHALL be 0 except IN_READY, which SHALL be 1 from the cycle after RST deasserts.
REQ-022 RST asserted mid-tile SHALL discard FIFO contents and the partial tile count; no TILE_DONE SHALL follow.
REQ-023 RST SHALL take priority over RUN and IN_VALID in the same cycle.

Structure
REQ-024 Package booth_r8_pkg SHALL hold the GC derivation, the digit-to-flags encode function and the group flag struct.
REQ-025 Sub-module booth_r8_enc SHALL encode one 4-bit window, combinationally, instantiated GC times.
REQ-026 The FIFO SHALL be inline register storage, with no memory macro.

Verification
REQ-027 X=0x07, Y=0x05, RUN=1 -> next cycle S=011, N=001, D=T=Q=000, Y_OUT=0x05, TMY_OUT=0x00F.
REQ-028 X=0x80, Y=0x80 -> D=100, N=100, S=T=Q=000, TMY_OUT=0x280.
REQ-029 X=0x7F -> S=001, N=001, D=100, T=Q=000; an exhaustive sweep of all 256 X values SHALL show the digit sum equal to X.
REQ-030 Push 5 beats with RUN=0 and DEPTH=4 -> IN_READY=0 after 4; then RUN=1 -> 4 encoded beats, then a bubble with UNDERRUN=1.
REQ-031 Stream 16 beats with IN_LAST on beat 16 -> one TILE_DONE aligned with beat 16 output, LAST_ERR=0; IN_LAST on beat 15 -> LAST_ERR=1 and sticky.
REQ-032 RST asserted after beat 7 of a tile -> outputs 0, count 0; the next 16 beats SHALL produce TILE_DONE on the 16th.
